// File: rtl/lif_array_if.sv
// lif_array_if -- bus bundle for the lif_array neuron array.
//   step       timestep strobe (master -> slave)
//   current    packed per-neuron currents, neuron i = current[i*W +: W]
//   threshold  shared firing threshold
//   sel        neuron selected for the state probe
//   spike      registered per-neuron spike pulses (slave -> master)
//   spike_any  OR of spike
//   state_out  registered membrane state of neuron sel
interface lif_array_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int SEL_W     = 2
);
  logic                   step;
  logic [N_NEURONS*W-1:0] current;
  logic [W-1:0]           threshold;
  logic [SEL_W-1:0]       sel;
  logic [N_NEURONS-1:0]   spike;
  logic                   spike_any;
  logic [W-1:0]           state_out;

  modport master (
    output step, current, threshold, sel,
    input  spike, spike_any, state_out
  );

  modport slave (
    input  step, current, threshold, sel,
    output spike, spike_any, state_out
  );
endinterface

// File: rtl/lif_array.sv
// lif_array -- array of N_NEURONS leaky integrate-and-fire neurons that share
// one programmable threshold.
//
// Each neuron, on a clock edge with step=1:
//   sum   = sat((state >> LEAK_SHIFT) + current)   (saturates at 2**W-1)
//   fire  = sum >= threshold
//   spike <= fire, state <= fire ? 0 : sum
// On edges with step=0 the state holds and spike returns to 0, so a spike is
// always a one-cycle pulse.
//
// Optional feature, macro LIF_REFRACTORY_EN: each neuron gets an 8-bit
// refractory counter loaded with REFRAC when it fires. While the counter is
// non-zero a step decrements it, ignores the input current (leak still
// applies) and cannot fire. With the macro undefined REFRAC is ignored.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears state, spikes, probe, counters)
//   bus    lif_array_if.slave: step/current/threshold/sel in,
//          spike/spike_any/state_out out

module lif_neuron #(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] thr_i,
  output logic         spike_o,
  output logic [W-1:0] state_o
);
  logic [W-1:0] state_q, state_d;
  logic         spike_q, spike_d;
  logic [W-1:0] decayed, cur_eff, sum_sat;
  logic [W:0]   sum;
  logic         refr, fire;

`ifdef LIF_REFRACTORY_EN
  logic [7:0] rc_q, rc_d;
  assign refr = (rc_q != 8'd0);
`else
  assign refr = 1'b0;
`endif

  // Datapath: leak, integrate, saturate, compare.
  always_comb begin
    decayed = state_q >> LEAK_SHIFT;
    cur_eff = refr ? '0 : cur_i;
    sum     = {1'b0, decayed} + {1'b0, cur_eff};
    // Carry out of the W-bit add means overflow: clamp to all-ones.
    sum_sat = sum[W] ? '1 : sum[W-1:0];
    fire    = !refr && (sum_sat >= thr_i);
  end

  always_comb begin
    state_d = state_q;
    spike_d = 1'b0;
`ifdef LIF_REFRACTORY_EN
    rc_d    = rc_q;
`endif
    if (step_i) begin
      spike_d = fire;
      state_d = fire ? '0 : sum_sat;
`ifdef LIF_REFRACTORY_EN
      // fire is already masked while refractory, so the two cases are exclusive.
      if (refr)
        rc_d = rc_q - 8'd1;
      else if (fire)
        rc_d = 8'(REFRAC);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      spike_q <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      rc_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
`ifdef LIF_REFRACTORY_EN
      rc_q    <= rc_d;
`endif
    end
  end

  assign spike_o = spike_q;
  assign state_o = state_q;
endmodule

module lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int SEL_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  lif_array_if.slave  bus
);
  // Reject parameter sets the datapath cannot represent.
  if (N_NEURONS < 1 || W < 2 || LEAK_SHIFT < 0 || LEAK_SHIFT >= W ||
      REFRAC < 0 || REFRAC > 255 || (1 << SEL_W) < N_NEURONS) begin : g_bad_cfg
    $error("lif_array: illegal parameter combination");
  end

  logic [N_NEURONS-1:0][W-1:0] cur_a;
  logic [N_NEURONS-1:0][W-1:0] state_a;
  logic [N_NEURONS-1:0]        spike_a;
  logic [W-1:0]                sel_state;
  logic [W-1:0]                state_out_q, state_out_d;

  assign cur_a = bus.current;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    lif_neuron #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_neuron (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (bus.step),
      .cur_i   (cur_a[g]),
      .thr_i   (bus.threshold),
      .spike_o (spike_a[g]),
      .state_o (state_a[g])
    );
  end

  // Probe mux; selects beyond the array read as zero.
  always_comb begin
    sel_state = '0;
    for (int i = 0; i < N_NEURONS; i++)
      if (int'(bus.sel) == i) sel_state = state_a[i];
  end

  // Samples the pre-edge state, so the probe trails updates by one cycle.
  assign state_out_d = sel_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_out_q <= '0;
    else        state_out_q <= state_out_d;
  end

  assign bus.spike     = spike_a;
  assign bus.spike_any = |spike_a;
  assign bus.state_out = state_out_q;
endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LS = 1;
  localparam int RF = 2;
  localparam int SW = 2;
`ifdef LIF_REFRACTORY_EN
  localparam bit REFR_ON = 1'b1;
`else
  localparam bit REFR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic step;
  logic [W-1:0] thr;
  logic [SW-1:0] sel;
  logic [N-1:0][W-1:0] cur_p;

  lif_array_if #(.N_NEURONS(N), .W(W), .SEL_W(SW)) bus();
  assign bus.step      = step;
  assign bus.threshold = thr;
  assign bus.sel       = sel;
  assign bus.current   = cur_p;

  lif_array #(.N_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .REFRAC(RF), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers following the neuron rules.
  int m_state[N];
  int m_rc[N];
  logic [N-1:0] m_spike;
  int m_sout;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_state[i] = 0; m_rc[i] = 0; end
    m_spike = '0;
    m_sout  = 0;
  endtask

  // One clock edge: update the model from the inputs in force, return at negedge.
  task automatic tick();
    int ns, c, s;
    bit refr, f;
    @(posedge clk);
    ns = (int'(sel) < N) ? m_state[sel] : 0;
    for (int i = 0; i < N; i++) begin
      if (step) begin
        refr = REFR_ON && (m_rc[i] != 0);
        c = refr ? 0 : int'(cur_p[i]);
        s = m_state[i] / (1 << LS) + c;
        if (s > 255) s = 255;
        f = !refr && (s >= int'(thr));
        m_spike[i] = f;
        m_state[i] = f ? 0 : s;
        if (refr) m_rc[i] = m_rc[i] - 1;
        else if (f) m_rc[i] = RF;
      end else begin
        m_spike[i] = 1'b0;
      end
    end
    m_sout = ns;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step = 1'b1; thr = 8'd200; sel = '0;
    for (int i = 0; i < N; i++) cur_p[i] = 8'd77;
    model_clear();
    #1;
    n_tests++;
    if (bus.spike !== 4'd0 || bus.spike_any !== 1'b0 || bus.state_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_initial spike=%b any=%b state_out=%0d expected 0/0/0", bus.spike, bus.spike_any, bus.state_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.spike !== 4'd0 || bus.spike_any !== 1'b0 || bus.state_out !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_held spike=%b any=%b state_out=%0d expected 0/0/0", bus.spike, bus.spike_any, bus.state_out);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    // Assert reset between edges: outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (bus.spike !== 4'd0 || bus.spike_any !== 1'b0 || bus.state_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async spike=%b any=%b state_out=%0d expected 0/0/0", bus.spike, bus.spike_any, bus.state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    n_tests++;
    if (bus.state_out !== 8'd77) begin
      n_fail++;
      $display("FAIL reset_restart state_out=%0d expected 77", bus.state_out);
    end
  endtask

  task automatic test_integrate();
    int tbl[10] = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};
    do_reset();
    thr = 8'd200; sel = 2'd0; step = 1'b1; cur_p = '0; cur_p[0] = 8'd100;
    for (int k = 0; k <= 10; k++) begin
      tick();
      n_tests++;
      if (bus.spike !== 4'd0 || bus.spike_any !== 1'b0 ||
          (k >= 1 && int'(bus.state_out) != tbl[k-1])) begin
        n_fail++;
        $display("FAIL integrate step%0d spike=%b state_out=%0d expected 0000/%0d", k + 1, bus.spike, bus.state_out, (k >= 1) ? tbl[k-1] : 0);
      end
    end
  endtask

  task automatic test_refractory();
`ifdef LIF_REFRACTORY_EN
    int st[8]  = '{120, 180, 0, 0, 0, 120, 180, 0};
    int spk[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
`else
    int st[8]  = '{120, 180, 0, 120, 180, 0, 120, 180};
    int spk[8] = '{0, 0, 1, 0, 0, 1, 0, 0};
`endif
    do_reset();
    thr = 8'd200; sel = 2'd0; step = 1'b1; cur_p = '0; cur_p[0] = 8'd120;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_tests++;
      if ((k < 8 && int'(bus.spike[0]) != spk[k]) ||
          (k >= 1 && int'(bus.state_out) != st[k-1])) begin
        n_fail++;
        $display("FAIL refractory step%0d spike0=%b state_out=%0d expected %0d/%0d", k + 1, bus.spike[0], bus.state_out, (k < 8) ? spk[k] : 0, (k >= 1) ? st[k-1] : 0);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    thr = 8'd255; sel = 2'd1; step = 1'b1; cur_p = '0; cur_p[1] = 8'd255;
    tick();
    n_tests++;
    if (bus.spike !== 4'b0010 || bus.spike_any !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate spike=%b any=%b expected 0010/1", bus.spike, bus.spike_any);
    end
    step = 1'b0;
    tick();
    n_tests++;
    if (bus.spike !== 4'b0000 || bus.spike_any !== 1'b0) begin
      n_fail++;
      $display("FAIL spike_pulse spike=%b any=%b expected 0000/0", bus.spike, bus.spike_any);
    end
  endtask

  task automatic test_hold();
    do_reset();
    thr = 8'd200; sel = 2'd0; step = 1'b1; cur_p = '0; cur_p[0] = 8'd100;
    tick(); tick(); tick();
    step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cur_p[0] = 8'($urandom_range(0, 255));
      tick();
      n_tests++;
      if (bus.state_out !== 8'd175 || bus.spike !== 4'd0) begin
        n_fail++;
        $display("FAIL hold cyc%0d state_out=%0d spike=%b expected 175/0000", k, bus.state_out, bus.spike);
      end
    end
    step = 1'b1; cur_p[0] = 8'd100;
    tick(); tick();
    n_tests++;
    if (bus.state_out !== 8'd187) begin
      n_fail++;
      $display("FAIL hold_resume state_out=%0d expected 187", bus.state_out);
    end
  endtask

  task automatic test_all_fire();
    do_reset();
    thr = 8'd150; sel = 2'd3; step = 1'b1;
    for (int i = 0; i < N; i++) cur_p[i] = 8'd200;
    tick();
    n_tests++;
    if (bus.spike !== 4'b1111 || bus.spike_any !== 1'b1) begin
      n_fail++;
      $display("FAIL all_fire spike=%b any=%b expected 1111/1", bus.spike, bus.spike_any);
    end
    step = 1'b0;
    tick();
    n_tests++;
    if (bus.state_out !== 8'd0 || bus.spike !== 4'd0) begin
      n_fail++;
      $display("FAIL all_fire_probe state_out=%0d spike=%b expected 0/0000", bus.state_out, bus.spike);
    end
  endtask

  task automatic test_random();
    do_reset();
    thr = 8'd180;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) thr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      for (int i = 0; i < N; i++) cur_p[i] = 8'($urandom_range(0, 140));
      step = ($urandom_range(0, 3) != 0);
      sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
      n_tests++;
      if (bus.spike !== m_spike || bus.spike_any !== (|m_spike) || int'(bus.state_out) != m_sout) begin
        n_fail++;
        $display("FAIL random cyc%0d spike=%b any=%b state_out=%0d expected %b/%b/%0d", k, bus.spike, bus.spike_any, bus.state_out, m_spike, |m_spike, m_sout);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_integrate();
    test_refractory();
    test_saturate();
    test_hold();
    test_all_fire();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
